// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a host controller and the PS/2 transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout_err;

  // Controller side: offers bytes, observes progress and completion.
  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_err, timeout_err
  );

  // Transmitter side.
  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_err, timeout_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then
// shifts out data, parity and stop on device clocks and checks the device ACK.
// ps2_clock_oe / ps2_data_oe are open-drain pull-down enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         ps2_clock_in,
  input  logic         ps2_data_in,
  output logic         ps2_clock_oe,
  output logic         ps2_data_oe,
  ps2_host_tx_if.slave tx
);

  // One counter serves both the inhibit interval and the transfer timeout,
  // so it is sized for the larger of the two.
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_WAIT_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       shift_q, shift_d;      // {parity, data}
  logic [3:0]       bit_cnt_q, bit_cnt_d;  // device falling edges seen in SEND
  logic             clock_oe_q, clock_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             ack_bit_q, ack_bit_d;  // data level sampled on edge 11 (0 = ACK)
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             timeout_err_q, timeout_err_d;

  logic [1:0] clk_sync_q, data_sync_q;
  logic       clk_prev_q;
  logic       clk_s, data_s, clk_fall;
  logic       ready, accept;

  // Two-flop synchronizers on the pins plus a delayed copy for edge detection.
  always_ff @(posedge clk_in or posedge reset) begin
    // NOTE: synchronizers reset to the idle bus level (1) so leaving reset never looks like a falling edge.
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clock_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign clk_s    = clk_sync_q[1];
  assign data_s   = data_sync_q[1];
  assign clk_fall = clk_prev_q & ~clk_s;

  // Not ready on the done/timeout pulse cycle, so a held request is taken one cycle later.
  assign ready  = (state_q == S_IDLE) && !done_q && !timeout_err_q;
  assign accept = ready && tx.tx_valid;

  // State register and registered line enables / status pulses.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      clock_oe_q    <= 1'b0;
      data_oe_q     <= 1'b0;
      ack_bit_q     <= 1'b1;
      done_q        <= 1'b0;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      clock_oe_q    <= clock_oe_d;
      data_oe_q     <= data_oe_d;
      ack_bit_q     <= ack_bit_d;
      done_q        <= done_d;
      ack_err_q     <= ack_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic: transfer sequencing, then the timeout override.
  always_comb begin
    // NOTE: every _d signal gets a default first so no path can infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    clock_oe_d    = clock_oe_q;
    data_oe_d     = data_oe_q;
    ack_bit_d     = ack_bit_q;
    done_d        = 1'b0;
    ack_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        clock_oe_d = 1'b0;
        data_oe_d  = 1'b0;
        if (accept) begin
          shift_d    = {~^tx.tx_data, tx.tx_data};  // odd parity
          cnt_d      = '0;
          clock_oe_d = 1'b1;
          state_d    = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          // Release clock and pull data low (start bit); timeout count starts at REQ.
          clock_oe_d = 1'b0;
          data_oe_d  = 1'b1;
          cnt_d      = '0;
          state_d    = S_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_REQ: begin
        bit_cnt_d = '0;
        state_d   = S_SEND;
      end

      S_SEND: begin
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q <= 4'd8) begin
            data_oe_d = ~shift_q[bit_cnt_q];  // data bits 0..7, then parity
          end else if (bit_cnt_q == 4'd9) begin
            data_oe_d = 1'b0;                 // stop bit: release
          end else begin
            ack_bit_d = data_s;
            state_d   = S_WAIT_IDLE;
          end
        end
      end

      S_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d    = 1'b1;
          ack_err_d = ack_bit_q;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A silent or stuck device must not hold the bus forever.
    if (state_q inside {S_REQ, S_SEND, S_WAIT_IDLE}) begin
      if (cnt_q == TIMEOUT_LAST) begin
        clock_oe_d    = 1'b0;
        data_oe_d     = 1'b0;
        done_d        = 1'b0;
        ack_err_d     = 1'b0;
        timeout_err_d = 1'b1;
        state_d       = S_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign ps2_clock_oe   = clock_oe_q;
  assign ps2_data_oe    = data_oe_q;
  assign tx.tx_ready    = ready;
  assign tx.busy        = ~ready;
  assign tx.done        = done_q;
  assign tx.ack_err     = ack_err_q;
  assign tx.timeout_err = timeout_err_q;

endmodule
